io_tile_top_param: RTL and testbench
====================================

Name: io_tile_top_param

Overview:
- Parametrised next-generation IO tile top, generic over IO pad count and interconnect width.
- Contains a double-buffered configuration chain: a shift chain plus an active configuration register loaded by an explicit commit.
- Per-pad and per-track source selection, with an optional output register for each.
- Per-pad output enable.
- Sits at the fabric edge between the IO ring and the interconnect; daisy-chained with other tiles on the config chain.

Parameters:
- IO_WIDTH, 4, number of IO pads.
- IC_WIDTH, 10, number of interconnect tracks.
- SEL_IC, 4, select width per pad; must be >= clog2(IC_WIDTH).
- SEL_IO, 2, select width per track; must be >= clog2(IO_WIDTH).
- CONFIG_WIDTH, IO_WIDTH*(SEL_IC+2)+IC_WIDTH*(SEL_IO+1), derived; 54 at defaults.

Ports:
- clock  input  1  tile clock.
- reset  input  1  asynchronous, active-high; clears all state.
- config_in  input  1  serial config data.
- config_out  output  1  serial chain output, equal to shadow[CONFIG_WIDTH-1].
- config_enable  input  1  shifts the chain one bit per cycle.
- config_commit  input  1  single-cycle strobe; copies shadow to active.
- config_valid  output  1  high once the first commit has occurred.
- enable  input  1  user-register clock enable.
- data_from_io  input  IO_WIDTH  pad inputs.
- data_to_io  output  IO_WIDTH  pad outputs.
- data_oe  output  IO_WIDTH  pad output enables.
- data_from_ic  input  IC_WIDTH  interconnect inputs.
- data_to_ic  output  IC_WIDTH  interconnect outputs.

Behaviour:
- Reset (async, active-high):
  - shadow, active, config_valid and all user registers go to 0.
  - Consequently config_out=0, data_to_io=0, data_oe=0, data_to_ic=0.
  - Reset asserted mid-shift or mid-commit discards all progress.
- Shift: when config_enable=1, shadow <= {shadow[CONFIG_WIDTH-2:0], config_in}.
  - config_out is a registered output; a bit entering config_in appears on config_out exactly CONFIG_WIDTH enabled cycles later.
  - When config_enable=0, shadow holds.
- Commit:
  - When config_commit=1, active <= shadow as it was before any same-cycle shift.
  - config_valid <= 1 and stays at 1 until reset.
  - The shadow shift still occurs if config_enable=1 in the same cycle.
  - Shifting never disturbs active; the fabric keeps running the old config while a new one loads.
- Active config layout (LSB first):
  - Pad field i at base i*(SEL_IC+2):
    - sel_ic[SEL_IC-1:0]
    - then reg_en
    - then oe
  - Track field j at base IO_WIDTH*(SEL_IC+2) + j*(SEL_IO+1):
    - sel_io[SEL_IO-1:0]
    - then reg_en
- Pad path, i:
  - src = data_from_ic[sel_ic] when sel_ic < IC_WIDTH, else 0.
  - q_io[i] <= src when enable=1 and config_valid=1; otherwise q_io[i] holds.
  - data_to_io[i] = oe ? (reg_en ? q_io[i] : src) : 0.
  - data_oe[i] = oe.
- Track path, j:
  - src = data_from_io[sel_io] when sel_io < IO_WIDTH, else 0.
  - q_ic[j] follows the same enable rule as q_io.
  - data_to_ic[j] = reg_en ? q_ic[j] : src.
- Latency:
  - Combinational mode: 0 cycles.
  - Registered mode: 1 enabled cycle.
- Before the first commit, all outputs are 0 regardless of inputs, because active=0 gives oe=0 and a track path of data_from_io[0] is masked by config_valid.
  - Implementation: data_to_ic is gated by config_valid.
- Commit does not clear q_io or q_ic. A path switched from combinational to registered shows the old q value until the next enabled cycle.

Test Plan:
- Reset then idle → all outputs 0 and config_valid=0. Toggle data_from_ic=10'h3FF → data_to_io remains 0.
- Shift 54 bits with config_enable=1 and no commit → config_out replays the first bit on the 55th cycle; data_to_io and data_to_ic unchanged.
- Load and commit: pad0 sel_ic=3, oe=1, reg_en=0; track5 sel_io=2, reg_en=1.
  - Drive data_from_ic[3]=1 → data_to_io[0]=1 and data_oe=4'b0001 the same cycle.
  - Drive data_from_io[2]=1 with enable=1 → data_to_ic[5]=1 one cycle later.
  - With enable=0 → data_to_ic[5] holds its old value.
- Set pad1 sel_ic=12 (≥ IC_WIDTH) with oe=1 → data_to_io[1]=0 for every data_from_ic pattern.
- config_commit and config_enable in the same cycle → active equals the pre-shift shadow; shadow equals the shifted value (check via config_out).
- Assert reset mid-shift after a valid commit → outputs 0 immediately (asynchronous), config_valid=0; a reload of all 54 bits plus commit restores correct operation.

Source files
------------

// File: rtl/io_tile_top_param.sv
// Parametrised IO tile: double-buffered serial config chain driving per-pad and
// per-track source muxes with optional output registers and per-pad output enables.
module io_tile_top_param #(
    parameter int unsigned IO_WIDTH = 4,
    parameter int unsigned IC_WIDTH = 10,
    parameter int unsigned SEL_IC   = 4,
    parameter int unsigned SEL_IO   = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                config_in,
    output logic                config_out,
    input  logic                config_enable,
    input  logic                config_commit,
    output logic                config_valid,
    input  logic                enable,
    input  logic [IO_WIDTH-1:0] data_from_io,
    output logic [IO_WIDTH-1:0] data_to_io,
    output logic [IO_WIDTH-1:0] data_oe,
    input  logic [IC_WIDTH-1:0] data_from_ic,
    output logic [IC_WIDTH-1:0] data_to_ic
);

    localparam int unsigned PAD_FW       = SEL_IC + 2;
    localparam int unsigned TRK_FW       = SEL_IO + 1;
    localparam int unsigned TRK_BASE     = IO_WIDTH * PAD_FW;
    localparam int unsigned CONFIG_WIDTH = TRK_BASE + IC_WIDTH * TRK_FW;
    localparam int unsigned IC_EXT       = 1 << SEL_IC;
    localparam int unsigned IO_EXT       = 1 << SEL_IO;

    logic [CONFIG_WIDTH-1:0] shadow;
    logic [CONFIG_WIDTH-1:0] active;
    logic                    valid_q;

    logic [IO_WIDTH-1:0] q_io;
    logic [IO_WIDTH-1:0] pad_src;
    logic [IO_WIDTH-1:0] pad_reg;
    logic [IO_WIDTH-1:0] pad_oe;

    logic [IC_WIDTH-1:0] q_ic;
    logic [IC_WIDTH-1:0] trk_src;
    logic [IC_WIDTH-1:0] trk_reg;

    // Zero-extended sources make out-of-range selects read back as 0 without a compare.
    logic [IC_EXT-1:0] ic_ext;
    logic [IO_EXT-1:0] io_ext;

    assign ic_ext = IC_EXT'(data_from_ic);
    assign io_ext = IO_EXT'(data_from_io);

    // Shift chain and committed configuration; commit samples the pre-shift shadow.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shadow  <= '0;
            active  <= '0;
            valid_q <= 1'b0;
        end else begin
            if (config_enable) begin
                shadow <= {shadow[CONFIG_WIDTH-2:0], config_in};
            end
            if (config_commit) begin
                active  <= shadow;
                valid_q <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < IO_WIDTH; i++) begin : g_pad
        localparam int unsigned BASE = i * PAD_FW;
        logic [SEL_IC-1:0] sel;
        assign sel        = active[BASE +: SEL_IC];
        assign pad_src[i] = ic_ext[sel];
        assign pad_reg[i] = active[BASE + SEL_IC];
        assign pad_oe[i]  = active[BASE + SEL_IC + 1];
    end

    for (genvar j = 0; j < IC_WIDTH; j++) begin : g_trk
        localparam int unsigned BASE = TRK_BASE + j * TRK_FW;
        logic [SEL_IO-1:0] sel;
        assign sel        = active[BASE +: SEL_IO];
        assign trk_src[j] = io_ext[sel];
        assign trk_reg[j] = active[BASE + SEL_IO];
    end

    // User registers advance only once a configuration is live.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q_io <= '0;
            q_ic <= '0;
        end else if (enable && valid_q) begin
            q_io <= pad_src;
            q_ic <= trk_src;
        end
    end

    assign config_out   = shadow[CONFIG_WIDTH-1];
    assign config_valid = valid_q;
    assign data_oe      = pad_oe;
    assign data_to_io   = pad_oe & ((pad_reg & q_io) | (~pad_reg & pad_src));
    // Masking by valid keeps unconfigured tracks (sel=0) from leaking data_from_io[0].
    assign data_to_ic   = {IC_WIDTH{valid_q}} & ((trk_reg & q_ic) | (~trk_reg & trk_src));

endmodule

// File: tb/tb_io_tile_top_param.sv
// Bench for io_tile_top_param: directed test-plan steps followed by randomized
// traffic, all checked against a bit-level behavioural model of the tile.
module tb_io_tile_top_param;

    localparam int unsigned IO_W = 4;
    localparam int unsigned IC_W = 10;
    localparam int unsigned CW   = 54;
    localparam int unsigned TB   = 24;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            config_in = 1'b0;
    logic            config_enable = 1'b0;
    logic            config_commit = 1'b0;
    logic            enable = 1'b0;
    logic [IO_W-1:0] data_from_io = '0;
    logic [IC_W-1:0] data_from_ic = '0;
    logic            config_out;
    logic            config_valid;
    logic [IO_W-1:0] data_to_io;
    logic [IO_W-1:0] data_oe;
    logic [IC_W-1:0] data_to_ic;

    io_tile_top_param dut (
        .clock        (clock),
        .reset        (reset),
        .config_in    (config_in),
        .config_out   (config_out),
        .config_enable(config_enable),
        .config_commit(config_commit),
        .config_valid (config_valid),
        .enable       (enable),
        .data_from_io (data_from_io),
        .data_to_io   (data_to_io),
        .data_oe      (data_oe),
        .data_from_ic (data_from_ic),
        .data_to_ic   (data_to_ic)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    logic [CW-1:0]   m_shadow = '0;
    logic [CW-1:0]   m_active = '0;
    logic            m_valid  = 1'b0;
    logic [IO_W-1:0] m_qio    = '0;
    logic [IC_W-1:0] m_qic    = '0;

    logic [CW-1:0] cfg_a;
    logic [CW-1:0] cfg_b;
    logic [CW-1:0] cfg_r;

    function automatic logic [CW-1:0] set_pad(logic [CW-1:0] c, int i, int sel, logic re, logic oe);
        logic [CW-1:0] r = c;
        r[i*6 +: 4] = 4'(sel);
        r[i*6 + 4]  = re;
        r[i*6 + 5]  = oe;
        return r;
    endfunction

    function automatic logic [CW-1:0] set_trk(logic [CW-1:0] c, int j, int sel, logic re);
        logic [CW-1:0] r = c;
        r[TB + j*3 +: 2] = 2'(sel);
        r[TB + j*3 + 2]  = re;
        return r;
    endfunction

    function automatic logic pad_src(int i);
        int sel = int'(m_active[i*6 +: 4]);
        return (sel < int'(IC_W)) ? data_from_ic[sel] : 1'b0;
    endfunction

    function automatic logic trk_src(int j);
        int sel = int'(m_active[TB + j*3 +: 2]);
        return (sel < int'(IO_W)) ? data_from_io[sel] : 1'b0;
    endfunction

    function automatic logic [IO_W-1:0] exp_to_io();
        logic [IO_W-1:0] r = '0;
        for (int i = 0; i < int'(IO_W); i++) begin
            if (m_active[i*6 + 5]) r[i] = m_active[i*6 + 4] ? m_qio[i] : pad_src(i);
        end
        return r;
    endfunction

    function automatic logic [IO_W-1:0] exp_oe();
        logic [IO_W-1:0] r = '0;
        for (int i = 0; i < int'(IO_W); i++) r[i] = m_active[i*6 + 5];
        return r;
    endfunction

    function automatic logic [IC_W-1:0] exp_to_ic();
        logic [IC_W-1:0] r = '0;
        if (m_valid) begin
            for (int j = 0; j < int'(IC_W); j++) begin
                r[j] = m_active[TB + j*3 + 2] ? m_qic[j] : trk_src(j);
            end
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".config_out"},   64'(config_out),   64'(m_shadow[CW-1]));
        chk({tag, ".config_valid"}, 64'(config_valid), 64'(m_valid));
        chk({tag, ".data_to_io"},   64'(data_to_io),   64'(exp_to_io()));
        chk({tag, ".data_oe"},      64'(data_oe),      64'(exp_oe()));
        chk({tag, ".data_to_ic"},   64'(data_to_ic),   64'(exp_to_ic()));
    endtask

    task automatic model_reset();
        m_shadow = '0;
        m_active = '0;
        m_valid  = 1'b0;
        m_qio    = '0;
        m_qic    = '0;
    endtask

    // Advance one clock; model next state is computed from the values present before the edge.
    task automatic tick(input string tag);
        logic [CW-1:0]   nsh;
        logic [CW-1:0]   nact;
        logic            nval;
        logic [IO_W-1:0] nqio;
        logic [IC_W-1:0] nqic;
        nsh  = config_enable ? {m_shadow[CW-2:0], config_in} : m_shadow;
        nact = config_commit ? m_shadow : m_active;
        nval = m_valid | config_commit;
        nqio = m_qio;
        nqic = m_qic;
        if (enable && m_valid) begin
            for (int i = 0; i < int'(IO_W); i++) nqio[i] = pad_src(i);
            for (int j = 0; j < int'(IC_W); j++) nqic[j] = trk_src(j);
        end
        @(posedge clock);
        #1;
        m_shadow = nsh;
        m_active = nact;
        m_valid  = nval;
        m_qio    = nqio;
        m_qic    = nqic;
        check_all(tag);
    endtask

    task automatic load(input logic [CW-1:0] c, input logic rand_commit);
        for (int k = int'(CW) - 1; k >= 0; k--) begin
            config_in     = c[k];
            config_enable = 1'b1;
            config_commit = rand_commit && ($urandom_range(0, 15) == 0);
            tick("load");
        end
        config_enable = 1'b0;
        config_commit = 1'b0;
    endtask

    task automatic commit();
        config_commit = 1'b1;
        tick("commit");
        config_commit = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        check_all("reset");
        chk("reset.valid0", 64'(config_valid), 64'(0));
        reset = 1'b0;

        // Idle, unconfigured tile ignores interconnect activity.
        data_from_ic = 10'h3FF;
        data_from_io = 4'hF;
        #1;
        check_all("idle");
        chk("idle.to_io0", 64'(data_to_io), 64'(0));
        chk("idle.to_ic0", 64'(data_to_ic), 64'(0));
        data_from_io = '0;

        // A single 1 followed by zeros reaches config_out after CW shifts.
        for (int n = 1; n <= int'(CW); n++) begin
            config_in     = (n == 1);
            config_enable = 1'b1;
            tick("shift");
            if (n == int'(CW) - 1) chk("shift.early", 64'(config_out), 64'(0));
        end
        chk("shift.replay", 64'(config_out), 64'(1));
        chk("shift.to_io", 64'(data_to_io), 64'(0));
        config_enable = 1'b0;

        cfg_a = set_pad('0, 0, 3, 1'b0, 1'b1);
        cfg_a = set_trk(cfg_a, 5, 2, 1'b1);
        load(cfg_a, 1'b0);
        commit();
        data_from_ic = 10'h008;
        #1;
        check_all("pad0");
        chk("pad0.comb", 64'(data_to_io), 64'(4'b0001));
        chk("pad0.oe", 64'(data_oe), 64'(4'b0001));
        data_from_io = 4'b0100;
        enable       = 1'b1;
        #1;
        chk("trk5.pre", 64'(data_to_ic[5]), 64'(0));
        tick("trk5");
        chk("trk5.reg", 64'(data_to_ic[5]), 64'(1));
        enable       = 1'b0;
        data_from_io = 4'b0000;
        tick("trk5h");
        chk("trk5.hold", 64'(data_to_ic[5]), 64'(1));

        // Pad1 select beyond the track count always drives 0.
        cfg_b = set_pad(cfg_a, 1, 12, 1'b0, 1'b1);
        load(cfg_b, 1'b0);
        commit();
        for (int n = 0; n < 8; n++) begin
            data_from_ic = (n == 0) ? 10'h3FF : 10'($urandom);
            #1;
            check_all("pad1oob");
            chk("pad1.oob", 64'(data_to_io[1]), 64'(0));
        end

        // Commit and shift in the same cycle: active takes the pre-shift shadow.
        load(cfg_a, 1'b0);
        config_in     = 1'b1;
        config_enable = 1'b1;
        config_commit = 1'b1;
        tick("same");
        config_enable = 1'b0;
        config_commit = 1'b0;
        chk("same.oe", 64'(data_oe), 64'(4'b0001));
        chk("same.cfg_out", 64'(config_out), 64'(cfg_a[CW-2]));

        // Asynchronous reset part way through a reload.
        data_from_ic = 10'h008;
        for (int n = 0; n < 20; n++) begin
            config_in     = cfg_b[int'(CW) - 1 - n];
            config_enable = 1'b1;
            tick("midshift");
        end
        chk("pre_rst.to_io", 64'(data_to_io), 64'(4'b0001));
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        chk("async_rst.valid", 64'(config_valid), 64'(0));
        chk("async_rst.to_io", 64'(data_to_io), 64'(0));
        chk("async_rst.oe", 64'(data_oe), 64'(0));
        config_enable = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        load(cfg_a, 1'b0);
        commit();
        #1;
        chk("restore.to_io", 64'(data_to_io), 64'(4'b0001));

        // Randomized configurations and traffic, with background shifting.
        for (int r = 0; r < 6; r++) begin
            cfg_r = CW'({$urandom(), $urandom()});
            load(cfg_r, 1'b1);
            commit();
            for (int c = 0; c < 20; c++) begin
                data_from_ic  = 10'($urandom);
                data_from_io  = 4'($urandom);
                enable        = 1'($urandom);
                config_in     = 1'($urandom);
                config_enable = ($urandom_range(0, 3) == 0);
                #1;
                check_all("rnd.comb");
                tick("rnd");
            end
            config_enable = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
